// File: rtl/regfile_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : regfile_write_arbiter                                      |
// | Description : Shares the register file's single write port between the  |
// |               ALU writeback (port 0) and the memory-load writeback       |
// |               (port 1) using round-robin arbitration.  The write-port    |
// |               outputs are registered.  A pending-write scoreboard tracks |
// |               destination registers reserved at issue, and reports busy  |
// |               flags for two read addresses.                              |
// | Optional    : REGZERO_PROTECT_EN - register 0 is never committed and is  |
// |               never marked pending (writes to it are still handshaken).  |
// | Ports       : clk, rst (async, active low)                               |
// |               aluValid/aluReady/aluReg/aluData    ALU write request      |
// |               memValid/memReady/memReg/memData    memory write request   |
// |               issueValid/issueReg                 reserve a destination  |
// |               dataOutRegisterA/B -> busyA/B       pending-write lookup   |
// |               dataIn/dataInRegister/enableSavingDataIn  reg-file port    |
// |               sbError (sticky double reserve), writeCount (commits)      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluReg,
  input  logic [DATA_WIDTH-1:0] aluData,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [ADDR_WIDTH-1:0] memReg,
  input  logic [DATA_WIDTH-1:0] memData,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueReg,
  input  logic [ADDR_WIDTH-1:0] dataOutRegisterA,
  input  logic [ADDR_WIDTH-1:0] dataOutRegisterB,
  output logic                  busyA,
  output logic                  busyB,
  output logic [DATA_WIDTH-1:0] dataIn,
  output logic [ADDR_WIDTH-1:0] dataInRegister,
  output logic                  enableSavingDataIn,
  output logic                  sbError,
  output logic [15:0]           writeCount
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // rr_ptr names the requester that wins the next tie (0 = ALU, 1 = MEM).
  logic                  rr_ptr;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_next;

  logic                  grant_alu;
  logic                  grant_mem;
  logic                  grant_any;
  logic                  commit_next;
  logic [ADDR_WIDTH-1:0] grant_reg;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  issue_effective;
  logic                  clear_hits_issue;

  // Grants double as the ready outputs; both are forced low during reset.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst) begin
      if (aluValid && (!memValid || !rr_ptr)) begin
        grant_alu = 1'b1;
      end else if (memValid) begin
        grant_mem = 1'b1;
      end
    end
  end

  assign grant_any  = grant_alu | grant_mem;
  assign grant_reg  = grant_mem ? memReg  : aluReg;
  assign grant_data = grant_mem ? memData : aluData;
  assign aluReady   = grant_alu;
  assign memReady   = grant_mem;

`ifdef REGZERO_PROTECT_EN
  // A grant to register 0 completes the handshake but is dropped here.
  assign commit_next     = grant_any && (grant_reg != '0);
  assign issue_effective = issueValid && (issueReg != '0);
`else
  assign commit_next     = grant_any;
  assign issue_effective = issueValid;
`endif

  // A commit retiring the same register being reserved is not a double reserve.
  assign clear_hits_issue = enableSavingDataIn && (dataInRegister == issueReg);

  // Clear first, then set, so a same-edge set/clear leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (enableSavingDataIn) begin
      pending_next[dataInRegister] = 1'b0;
    end
    if (issue_effective) begin
      pending_next[issueReg] = 1'b1;
    end
`ifdef REGZERO_PROTECT_EN
    pending_next[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataIn             <= '0;
      dataInRegister     <= '0;
      enableSavingDataIn <= 1'b0;
      pending            <= '0;
      sbError            <= 1'b0;
      writeCount         <= '0;
      rr_ptr             <= 1'b0;
    end else begin
      enableSavingDataIn <= commit_next;
      pending            <= pending_next;
      if (commit_next) begin
        dataIn         <= grant_data;
        dataInRegister <= grant_reg;
      end
      // Point at the requester that just lost (ALU granted -> MEM next).
      if (grant_any) begin
        rr_ptr <= grant_alu;
      end
      if (enableSavingDataIn) begin
        writeCount <= writeCount + 16'd1;
      end
      if (issue_effective && pending[issueReg] && !clear_hits_issue) begin
        sbError <= 1'b1;
      end
    end
  end

  assign busyA = pending[dataOutRegisterA];
  assign busyB = pending[dataOutRegisterB];

endmodule
`default_nettype wire
